// File: rtl/pipe_select_mux.sv
// ---------------------------------------------------------------------------
// pipe_select_mux
//
// Pipelined NUM_IN-to-1 word selector for the operand and forwarding paths.
// A combinational decode picks one of the packed inputs. One input can be
// marked as narrow, and only its low NARROW_W bits are passed, zero-extended.
// A select that is out of range produces ERR_VAL and raises an error bit.
// The result then passes through DEPTH register stages that support stall
// and flush. The design also keeps a saturating count of accepted
// out-of-range selects.
//
// Ports
//   Clk        rising-edge clock
//   Rst        synchronous active-high reset
//   in_bus     packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input select
//   in_valid   qualifies sel / in_bus this cycle
//   stall      freezes every stage
//   flush      invalidates every stage (wins over stall)
//   out        selected word from the last stage
//   out_valid  out holds a valid accepted word
//   out_err    last-stage word came from an out-of-range select
//   err_count  saturating count of accepted out-of-range selects
// ---------------------------------------------------------------------------
module pipe_select_mux #(
    parameter int              WIDTH      = 32,
    parameter int              NUM_IN     = 3,
    parameter int              SEL_W      = 2,
    parameter int              DEPTH      = 1,
    parameter int              NARROW_IDX = 2,
    parameter int              NARROW_W   = 5,
    parameter logic [WIDTH-1:0] ERR_VAL   = {WIDTH{1'b1}}
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_IN*WIDTH-1:0]  in_bus,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out,
    output logic                     out_valid,
    output logic                     out_err,
    output logic [7:0]               err_count
);

    // Keeps the significant bits of the narrow input. The right shift avoids
    // overflowing the mask when NARROW_W equals WIDTH.
    localparam logic [WIDTH-1:0] NARROW_MASK =
        (NARROW_W >= WIDTH) ? {WIDTH{1'b1}}
                            : ({WIDTH{1'b1}} >> (WIDTH - NARROW_W));

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---- stage 0: combinational select decode ----
    logic [WIDTH-1:0] data_p0;
    logic             err_p0;
    logic             accept_p0;

    always_comb begin
        data_p0 = ERR_VAL;
        err_p0  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(sel) == k) begin
                err_p0 = 1'b0;
                if (k == NARROW_IDX) begin
                    data_p0 = in_bus[k*WIDTH +: WIDTH] & NARROW_MASK;
                end else begin
                    data_p0 = in_bus[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // A select counts only if it actually enters the pipeline.
    assign accept_p0 = in_valid & ~stall & ~flush;

    // ---- stages 1..DEPTH: register pipeline (index i holds stage i+1) ----
    logic [WIDTH-1:0] data_p [DEPTH];
    logic             vld_p  [DEPTH];
    logic             err_p  [DEPTH];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_p[i] <= '0;
                vld_p[i]  <= 1'b0;
                err_p[i]  <= 1'b0;
            end
        end else if (flush) begin
            // Data is left in place; it is don't-care while invalid.
            for (int i = 0; i < DEPTH; i++) begin
                vld_p[i] <= 1'b0;
                err_p[i] <= 1'b0;
            end
        end else if (!stall) begin
            data_p[0] <= data_p0;
            vld_p[0]  <= in_valid;
            // An invalid cycle never carries an error into the pipeline.
            err_p[0]  <= in_valid & err_p0;
            for (int i = 1; i < DEPTH; i++) begin
                data_p[i] <= data_p[i-1];
                vld_p[i]  <= vld_p[i-1];
                err_p[i]  <= err_p[i-1];
            end
        end
    end

    // ---- error counter: updates on the accepting edge ----
    logic [7:0] err_count_r;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            err_count_r <= 8'd0;
        end else if (accept_p0 && err_p0) begin
            err_count_r <= sat_inc8(err_count_r);
        end
    end

    // ---- outputs: registered only ----
    assign out       = data_p[DEPTH-1];
    assign out_valid = vld_p[DEPTH-1];
    assign out_err   = err_p[DEPTH-1];
    assign err_count = err_count_r;

endmodule

// File: tb/tb_pipe_select_mux.sv
// ---------------------------------------------------------------------------
// Testbench for pipe_select_mux. Three instances, with DEPTH 1, 2 and 3,
// share the same stimulus. Each accepted word is pushed to a per-instance
// queue together with the advance count at which it was accepted. The word
// is popped when that instance shows a new valid output.
// ---------------------------------------------------------------------------
module tb_pipe_select_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] in_bus;
    logic [1:0]  sel;
    logic        in_valid;
    logic        stall;
    logic        flush;

    logic [31:0] o  [3];
    logic        ov [3];
    logic        oe [3];
    logic [7:0]  ec [3];

    always #5 clk = ~clk;

    pipe_select_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEPTH(1),
                      .NARROW_IDX(2), .NARROW_W(5)) u_d1 (
        .Clk(clk), .Rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o[0]), .out_valid(ov[0]),
        .out_err(oe[0]), .err_count(ec[0]));

    pipe_select_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEPTH(2),
                      .NARROW_IDX(2), .NARROW_W(5)) u_d2 (
        .Clk(clk), .Rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o[1]), .out_valid(ov[1]),
        .out_err(oe[1]), .err_count(ec[1]));

    pipe_select_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEPTH(3),
                      .NARROW_IDX(2), .NARROW_W(5)) u_d3 (
        .Clk(clk), .Rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(o[2]), .out_valid(ov[2]),
        .out_err(oe[2]), .err_count(ec[2]));

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          born;
    } ent_t;

    ent_t        q [3][$];
    int          dep [3];
    int          adv_cnt;
    logic [7:0]  errm;
    int          n_vec;
    int          n_mis;

    function automatic logic [31:0] exp_word(input logic [1:0] s, input logic [95:0] b);
        case (s)
            2'd0:    return b[31:0];
            2'd1:    return b[63:32];
            2'd2:    return {27'd0, b[68:64]};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from the pre-edge controls, then check.
    task automatic step();
        logic [31:0] pre_o [3];
        logic        pre_v [3];
        logic        pre_e [3];
        logic        r, f, s, acc, expv;
        logic [1:0]  sl;
        logic [95:0] bus;
        ent_t        e;
        for (int i = 0; i < 3; i++) begin
            pre_o[i] = o[i];
            pre_v[i] = ov[i];
            pre_e[i] = oe[i];
        end
        r   = rst;
        f   = flush;
        s   = stall;
        sl  = sel;
        bus = in_bus;
        acc = in_valid && !s && !f && !r;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            errm = 8'd0;
        end else if (f) begin
            for (int i = 0; i < 3; i++) q[i].delete();
        end else if (!s) begin
            adv_cnt++;
            if (acc) begin
                e.d    = exp_word(sl, bus);
                e.e    = (sl == 2'd3);
                e.born = adv_cnt;
                for (int i = 0; i < 3; i++) q[i].push_back(e);
            end
        end
        if (acc && sl == 2'd3 && errm != 8'hFF) errm = errm + 8'd1;

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("err_count_d%0d", dep[i]), {24'd0, ec[i]}, {24'd0, errm});
            if (r) begin
                chk($sformatf("rst_out_d%0d", dep[i]), o[i], 32'd0);
                chk($sformatf("rst_valid_d%0d", dep[i]), {31'd0, ov[i]}, 32'd0);
                chk($sformatf("rst_err_d%0d", dep[i]), {31'd0, oe[i]}, 32'd0);
            end else if (f) begin
                chk($sformatf("flush_valid_d%0d", dep[i]), {31'd0, ov[i]}, 32'd0);
                chk($sformatf("flush_err_d%0d", dep[i]), {31'd0, oe[i]}, 32'd0);
            end else if (s) begin
                chk($sformatf("stall_out_d%0d", dep[i]), o[i], pre_o[i]);
                chk($sformatf("stall_valid_d%0d", dep[i]), {31'd0, ov[i]}, {31'd0, pre_v[i]});
                chk($sformatf("stall_err_d%0d", dep[i]), {31'd0, oe[i]}, {31'd0, pre_e[i]});
            end else begin
                expv = (q[i].size() > 0) && (adv_cnt - q[i][0].born == dep[i] - 1);
                chk($sformatf("valid_d%0d", dep[i]), {31'd0, ov[i]}, {31'd0, expv});
                if (expv) begin
                    e = q[i].pop_front();
                    chk($sformatf("out_d%0d", dep[i]), o[i], e.d);
                    chk($sformatf("err_d%0d", dep[i]), {31'd0, oe[i]}, {31'd0, e.e});
                end else begin
                    chk($sformatf("idle_err_d%0d", dep[i]), {31'd0, oe[i]}, 32'd0);
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic st, input logic fl);
        in_valid = v;
        sel      = s;
        stall    = st;
        flush    = fl;
        step();
    endtask

    logic [7:0] ec_before;

    initial begin
        dep[0] = 1; dep[1] = 2; dep[2] = 3;
        adv_cnt = 0; errm = 8'd0; n_vec = 0; n_mis = 0;
        rst = 1'b1; in_valid = 1'b0; sel = 2'd0; stall = 1'b0; flush = 1'b0;
        in_bus = {32'hFFFF_FFE7, 32'h2222_2222, 32'h1111_1111};

        // Reset state
        step();
        step();
        rst = 1'b0;

        // Basic select including the narrow input
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        // Out-of-range selects: count to 3, then saturate
        for (int k = 0; k < 3; k++) drive(1'b1, 2'd3, 1'b0, 1'b0);
        chk("err_count_3", {24'd0, ec[0]}, 32'd3);
        for (int k = 0; k < 300; k++) drive(1'b1, 2'd3, 1'b0, 1'b0);
        chk("err_count_sat", {24'd0, ec[2]}, 32'd255);

        // Out-of-range select while invalid: no count, no err bit
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd3, 1'b0, 1'b0);
        chk("err_count_hold", {24'd0, ec[1]}, 32'd255);

        // Stream 0,1,0,1 with a 2-cycle stall after the second word
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        // Flush together with stall while two words are in flight
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        chk("flush_stall_valid", {31'd0, ov[1]}, 32'd0);
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        // Flush with an out-of-range select: dropped, not counted
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        ec_before = ec[0];
        drive(1'b1, 2'd3, 1'b0, 1'b1);
        chk("flush_no_count", {24'd0, ec[0]}, {24'd0, ec_before});
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        // Reset mid-stream with err_count = 5
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) drive(1'b1, 2'd3, 1'b0, 1'b0);
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        chk("err_count_5", {24'd0, ec[2]}, 32'd5);
        rst = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        chk("rst_mid_count", {24'd0, ec[2]}, 32'd0);
        chk("rst_mid_valid", {31'd0, ov[2]}, 32'd0);
        rst = 1'b0;
        in_bus = {$urandom, $urandom, $urandom};
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        // Mixed random traffic
        for (int k = 0; k < 80; k++) begin
            in_bus = {$urandom, $urandom, $urandom};
            drive(($urandom % 4) != 0, 2'($urandom % 4),
                  ($urandom % 5) == 0, ($urandom % 11) == 0);
        end
        for (int k = 0; k < 4; k++) drive(1'b0, 2'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
